// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: evaluates one result bit per clock, LSB first.
// Optional even-parity output P is built when SERIAL_LOGIC_UNIT_PARITY_EN is defined.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic             Z,
  output logic [1:0]       o_dbg_state
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
  ,
  output logic             P
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_z;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
  logic             r_p;
`endif

  logic             w_bit;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      3'b000:  w_bit = ~r_a_sh[0];
      3'b001:  w_bit = r_a_sh[0] & r_b_sh[0];
      3'b010:  w_bit = r_a_sh[0] | r_b_sh[0];
      3'b011:  w_bit = r_a_sh[0] ^ r_b_sh[0];
      3'b100:  w_bit = ~(r_a_sh[0] & r_b_sh[0]);
      3'b101:  w_bit = ~(r_a_sh[0] | r_b_sh[0]);
      3'b110:  w_bit = ~(r_a_sh[0] ^ r_b_sh[0]);
      default: w_bit = r_a_sh[0];
    endcase
  end

  assign w_acc_next = {w_bit, r_acc[WIDTH-1:1]};

  // start is honoured in IDLE and DONE only; anything else decodes to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_z     <= 1'b0;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
      r_p     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sh  <= A;
            r_b_sh  <= B;
            r_op    <= op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_acc  <= w_acc_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_y     <= w_acc_next;
            r_z     <= (w_acc_next == '0);
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
            r_p     <= ^w_acc_next;
`endif
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign S           = (r_state == BUSY) ? w_bit : 1'b0;
  assign Y           = r_y;
  assign Z           = r_z;
  assign busy        = (r_state == BUSY);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
  assign P           = r_p;
`endif

endmodule
